// File: rtl/ans_bit_packer.sv
// ans_bit_packer: packs variable-length code chunks MSB-first into fixed-width
// output words. A chunk flagged last flushes the stream with a zero-padded,
// tagged final word (always emitted, even on an exact word boundary).
module ans_bit_packer #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned LEN_WIDTH = 4,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned PAD_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  in_bits,
    input  logic [LEN_WIDTH-1:0] in_len,
    input  logic                 in_last,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [OUT_WIDTH-1:0] out_byte,
    output logic                 out_last,
    output logic [PAD_WIDTH-1:0] out_pad,
    output logic                 out_vld,
    input  logic                 out_rdy
);

    // Buffer holds at most OUT_WIDTH-1 leftover bits plus one full chunk.
    localparam int unsigned BUF_WIDTH = OUT_WIDTH + IN_WIDTH - 1;
    localparam int unsigned CNT_WIDTH = $clog2(BUF_WIDTH + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_OUT = CNT_WIDTH'(OUT_WIDTH);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(IN_WIDTH);
    localparam logic [PAD_WIDTH-1:0] PAD_OUT = PAD_WIDTH'(OUT_WIDTH);

    // State: valid bits are right-aligned in buf_q[cnt_q-1:0]; bits above
    // cnt_q are stale and never reach an output word.
    logic [BUF_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last_pend_q, last_pend_d;
    logic [OUT_WIDTH-1:0] out_byte_q, out_byte_d;
    logic                 out_last_q, out_last_d;
    logic [PAD_WIDTH-1:0] out_pad_q, out_pad_d;
    logic                 out_vld_q, out_vld_d;

    logic [LEN_WIDTH-1:0] len_sat;
    logic [BUF_WIDTH-1:0] len_mask;
    logic [BUF_WIDTH-1:0] data_in;
    logic [OUT_WIDTH-1:0] word_full;
    logic [OUT_WIDTH-1:0] word_part;
    logic                 accept;
    logic                 slot_free;
    logic                 have_full;
    logic                 emit_full;
    logic                 emit_final;
    logic                 consume;

    // Handshake and datapath decode for the current cycle.
    always_comb begin
        len_sat  = (in_len > LEN_MAX) ? LEN_MAX : in_len;
        len_mask = ~({BUF_WIDTH{1'b1}} << len_sat);
        data_in  = BUF_WIDTH'(in_bits) & len_mask;

        in_rdy    = en && (cnt_q < CNT_OUT) && !last_pend_q;
        accept    = in_vld && in_rdy;
        slot_free = !out_vld_q || (out_rdy && en);
        have_full = (cnt_q >= CNT_OUT);
        emit_full  = en && slot_free && have_full;
        // Covers both the partial final word and the empty final word.
        emit_final = en && slot_free && last_pend_q && !have_full;
        consume    = en && out_vld_q && out_rdy;

        // Oldest OUT_WIDTH valid bits: buf_q[cnt_q-1 -: OUT_WIDTH].
        word_full = OUT_WIDTH'(buf_q >> (cnt_q - CNT_OUT));
        // Remaining bits left-aligned; a zero count shifts everything out.
        word_part = OUT_WIDTH'(buf_q << (CNT_OUT - cnt_q));
    end

    // Next-state: accept a chunk, or emit a word, or retire a consumed word.
    always_comb begin
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        last_pend_d = last_pend_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        out_pad_d   = out_pad_q;
        out_vld_d   = out_vld_q;

        // Accept needs cnt < OUT_WIDTH, so it never coincides with emit_full,
        // and it needs !last_pend, so it never coincides with emit_final.
        if (accept) begin
            buf_d = (buf_q << len_sat) | data_in;
            cnt_d = cnt_q + CNT_WIDTH'(len_sat);
            if (in_last) begin
                last_pend_d = 1'b1;
            end
        end

        if (emit_full) begin
            out_byte_d = word_full;
            out_vld_d  = 1'b1;
            cnt_d      = cnt_q - CNT_OUT;
            out_pad_d  = '0;
            if (last_pend_q && (cnt_q == CNT_OUT)) begin
                out_last_d  = 1'b1;
                last_pend_d = 1'b0;
            end else begin
                out_last_d = 1'b0;
            end
        end else if (emit_final) begin
            out_byte_d  = word_part;
            out_vld_d   = 1'b1;
            out_last_d  = 1'b1;
            out_pad_d   = PAD_OUT - PAD_WIDTH'(cnt_q);
            cnt_d       = '0;
            last_pend_d = 1'b0;
        end else if (consume) begin
            out_vld_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
            out_byte_q  <= '0;
            out_last_q  <= 1'b0;
            out_pad_q   <= '0;
            out_vld_q   <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
            out_pad_q   <= out_pad_d;
            out_vld_q   <= out_vld_d;
        end
    end

    assign out_byte = out_byte_q;
    assign out_last = out_last_q;
    assign out_pad  = out_pad_q;
    assign out_vld  = out_vld_q;

endmodule

// File: tb/tb_ans_bit_packer.sv
// Directed bench for ans_bit_packer: hand-computed words per scenario.
module tb_ans_bit_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] in_bits;
    logic [3:0] in_len;
    logic       in_last;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] out_byte;
    logic       out_last;
    logic [3:0] out_pad;
    logic       out_vld;
    logic       out_rdy;

    int checks = 0;
    int fails  = 0;

    // Consumed words as {byte, last, pad}.
    logic [12:0] q[$];

    ans_bit_packer #(
        .IN_WIDTH (8),
        .LEN_WIDTH(4),
        .OUT_WIDTH(8),
        .PAD_WIDTH(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_bits (in_bits),
        .in_len  (in_len),
        .in_last (in_last),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .out_byte(out_byte),
        .out_last(out_last),
        .out_pad (out_pad),
        .out_vld (out_vld),
        .out_rdy (out_rdy)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so the negedge view predicts the handshake.
    always @(negedge clk) begin
        if (rst_n && en && out_vld && out_rdy) q.push_back({out_byte, out_last, out_pad});
    end

    // Offer one chunk until accepted; caller is positioned just after a posedge.
    task automatic send(input logic [7:0] b, input logic [3:0] l, input logic last);
        bit done = 0;
        in_bits = b; in_len = l; in_last = last; in_vld = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_rdy) done = 1;
            @(posedge clk); #1;
        end
        in_vld = 1'b0; in_last = 1'b0; in_bits = '0; in_len = '0;
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL send_accept: chunk %h len %0d not accepted, required accept", b, l);
        end
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 60 && q.size() < n; i++) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic wait_out_vld();
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (out_vld) seen = 1;
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL out_vld_timeout: got out_vld=0, required 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; out_rdy = 1'b0;
        in_bits = '0; in_len = '0; in_last = 1'b0; in_vld = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_vld, out_byte, out_last, out_pad} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {out_vld, out_byte, out_last, out_pad});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got in_rdy=%b out_vld=%b, required 1 0", in_rdy, out_vld);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nibbles();
        q.delete(); out_rdy = 1'b1;
        send(8'h0A, 4'd4, 1'b0);
        send(8'h0B, 4'd4, 1'b0);
        send(8'h0C, 4'd4, 1'b0);
        send(8'h0D, 4'd4, 1'b1);
        wait_words(2);
        checks++;
        if (q.size() != 2) begin
            fails++; $display("FAIL nibbles_count: got %0d words, required 2", q.size());
        end
        checks++;
        if (q[0] !== {8'hAB, 1'b0, 4'd0}) begin
            fails++; $display("FAIL nibbles_word0: got %h, required %h", q[0], {8'hAB, 1'b0, 4'd0});
        end
        checks++;
        if (q[1] !== {8'hCD, 1'b1, 4'd0}) begin
            fails++; $display("FAIL nibbles_word1: got %h, required %h", q[1], {8'hCD, 1'b1, 4'd0});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || q.size() != 2) begin
            fails++;
            $display("FAIL nibbles_idle: got in_rdy=%b out_vld=%b words=%0d, required 1 0 2",
                     in_rdy, out_vld, q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unaligned();
        q.delete(); out_rdy = 1'b1;
        send(8'h05, 4'd3, 1'b0);
        send(8'h66, 4'd7, 1'b1);
        wait_words(2);
        checks++;
        if (q.size() != 2) begin
            fails++; $display("FAIL unaligned_count: got %0d words, required 2", q.size());
        end
        checks++;
        if (q[0] !== {8'hB9, 1'b0, 4'd0}) begin
            fails++; $display("FAIL unaligned_word0: got %h, required %h", q[0], {8'hB9, 1'b0, 4'd0});
        end
        checks++;
        if (q[1] !== {8'h80, 1'b1, 4'd6}) begin
            fails++; $display("FAIL unaligned_word1: got %h, required %h", q[1], {8'h80, 1'b1, 4'd6});
        end
    endtask

    task automatic test_backpressure();
        q.delete(); out_rdy = 1'b0;
        send(8'hFF, 4'd8, 1'b0);
        fork
            send(8'h00, 4'd8, 1'b1);
            begin
                wait_out_vld();
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    checks++;
                    if ({out_vld, out_byte} !== {1'b1, 8'hFF}) begin
                        fails++;
                        $display("FAIL bp_hold: cycle %0d got vld=%b byte=%h, required 1 ff",
                                 i, out_vld, out_byte);
                    end
                    if (i > 0) begin
                        checks++;
                        if (in_rdy !== 1'b0) begin
                            fails++;
                            $display("FAIL bp_in_rdy: cycle %0d got %b, required 0", i, in_rdy);
                        end
                    end
                end
                checks++;
                if (q.size() != 0) begin
                    fails++; $display("FAIL bp_no_consume: got %0d words, required 0", q.size());
                end
            end
        join
        @(posedge clk); #1; out_rdy = 1'b1;
        wait_words(2);
        checks++;
        if (q.size() != 2) begin
            fails++; $display("FAIL bp_count: got %0d words, required 2", q.size());
        end
        checks++;
        if (q[0] !== {8'hFF, 1'b0, 4'd0}) begin
            fails++; $display("FAIL bp_word0: got %h, required %h", q[0], {8'hFF, 1'b0, 4'd0});
        end
        checks++;
        if (q[1] !== {8'h00, 1'b1, 4'd0}) begin
            fails++; $display("FAIL bp_word1: got %h, required %h", q[1], {8'h00, 1'b1, 4'd0});
        end
    endtask

    task automatic test_empty_last();
        q.delete(); out_rdy = 1'b1;
        send(8'h00, 4'd0, 1'b1);
        wait_words(1);
        checks++;
        if (q.size() != 1 || q[0] !== {8'h00, 1'b1, 4'd8}) begin
            fails++;
            $display("FAIL empty_last: got %0d words first %h, required 1 %h",
                     q.size(), q[0], {8'h00, 1'b1, 4'd8});
        end
    endtask

    task automatic test_len_saturate();
        q.delete(); out_rdy = 1'b1;
        send(8'hFF, 4'd12, 1'b1);
        wait_words(1);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 1 || q[0] !== {8'hFF, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL len_saturate: got %0d words first %h, required 1 %h",
                     q.size(), q[0], {8'hFF, 1'b1, 4'd0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_enable();
        q.delete(); out_rdy = 1'b0;
        send(8'h0A, 4'd4, 1'b0);
        send(8'h0B, 4'd4, 1'b0);
        wait_out_vld();
        @(posedge clk); #1; en = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({out_vld, out_byte, out_last, out_pad, in_rdy} !== {1'b1, 8'hAB, 1'b0, 4'd0, 1'b0}) begin
                fails++;
                $display("FAIL en_hold: cycle %0d got vld=%b byte=%h last=%b pad=%0d rdy=%b, required 1 ab 0 0 0",
                         i, out_vld, out_byte, out_last, out_pad, in_rdy);
            end
        end
        @(posedge clk); #1; en = 1'b1;
        send(8'h0C, 4'd4, 1'b1);
        wait_words(2);
        checks++;
        if (q.size() != 2) begin
            fails++; $display("FAIL en_count: got %0d words, required 2", q.size());
        end
        checks++;
        if (q[0] !== {8'hAB, 1'b0, 4'd0}) begin
            fails++; $display("FAIL en_word0: got %h, required %h", q[0], {8'hAB, 1'b0, 4'd0});
        end
        checks++;
        if (q[1] !== {8'hC0, 1'b1, 4'd4}) begin
            fails++; $display("FAIL en_word1: got %h, required %h", q[1], {8'hC0, 1'b1, 4'd4});
        end
    endtask

    task automatic test_reset_midstream();
        q.delete(); out_rdy = 1'b0;
        send(8'hFF, 4'd8, 1'b0);
        wait_out_vld();
        @(posedge clk); #1;
        send(8'h15, 4'd5, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_vld, out_byte, out_last, out_pad} !== 14'h0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h, required 0",
                     {out_vld, out_byte, out_last, out_pad});
        end
        @(posedge clk); #1; rst_n = 1'b1; out_rdy = 1'b1; q.delete();
        send(8'h03, 4'd4, 1'b0);
        send(8'h0C, 4'd4, 1'b1);
        wait_words(1);
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 1 || q[0] !== {8'h3C, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL midreset_stream: got %0d words first %h, required 1 %h",
                     q.size(), q[0], {8'h3C, 1'b1, 4'd0});
        end
    endtask

    initial begin
        test_reset();
        test_nibbles();
        test_unaligned();
        test_backpressure();
        test_empty_last();
        test_len_saturate();
        test_enable();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ans_bit_packer.md
Name: ans_bit_packer

Overview:
- Downstream stage of the ANS encoder.
- Accepts variable-length bit chunks (code bits plus a length) over a valid/ready handshake and packs them MSB-first into fixed-width output bytes for the output pins.
- A chunk flagged last flushes the stream: the final partial byte is zero-padded and tagged with out_last and a pad count.

Parameters:
- IN_WIDTH, 8, maximum bits per input chunk.
- LEN_WIDTH, 4, width of in_len; must satisfy 2^LEN_WIDTH > IN_WIDTH.
- OUT_WIDTH, 8, output word width in bits.
- PAD_WIDTH, 4, width of out_pad; must hold the value OUT_WIDTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable; when low all state freezes
- in_bits  input  IN_WIDTH  chunk bits, right-aligned; valid bits are in_bits[in_len-1:0]
- in_len  input  LEN_WIDTH  number of valid bits, 0..IN_WIDTH
- in_last  input  1  chunk ends the stream
- in_vld  input  1  chunk valid
- in_rdy  output  1  packer can accept a chunk
- out_byte  output  OUT_WIDTH  packed word; first bit in the stream is the MSB
- out_last  output  1  word is the final word of the stream
- out_pad  output  PAD_WIDTH  zero pad bits at the LSB end of a final word
- out_vld  output  1  out_byte valid
- out_rdy  input  1  consumer accepts the word

Behaviour:
- Reset and clocking: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: out_vld=0, out_byte=0, out_last=0, out_pad=0, internal fill count cnt=0, bit buffer=0, last_pend=0.
- Reset mid-stream discards all buffered bits and any pending word.
- Internal bit buffer: width OUT_WIDTH+IN_WIDTH-1. cnt holds the number of valid bits, right-aligned.
- in_rdy is combinational: en && cnt < OUT_WIDTH && !last_pend.
- Accept occurs when in_vld && in_rdy at a rising edge:
  - buffer <= (buffer << len) | (in_bits & mask(len)); cnt <= cnt + len.
  - len = min(in_len, IN_WIDTH). Out-of-range lengths saturate.
  - Bits of in_bits above len are ignored.
  - If in_last is set, last_pend <= 1.
- Output slot is free when !out_vld, or when out_vld && out_rdy && en in this cycle.
- Emit full word: when cnt >= OUT_WIDTH and the slot is free:
  - out_byte <= buffer[cnt-1 -: OUT_WIDTH]; cnt <= cnt - OUT_WIDTH; out_vld <= 1.
  - If last_pend and cnt == OUT_WIDTH: out_last <= 1, out_pad <= 0, last_pend <= 0.
- Emit final partial word: when last_pend, 0 < cnt < OUT_WIDTH, and the slot is free:
  - out_byte <= remaining bits left-aligned, zero-filled below.
  - out_last <= 1; out_pad <= OUT_WIDTH - cnt; cnt <= 0; last_pend <= 0.
- Empty final word: when last_pend, cnt == 0, and the slot is free:
  - out_byte <= 0; out_last <= 1; out_pad <= OUT_WIDTH; last_pend <= 0.
  - The final word is therefore always emitted, even if the stream ends exactly on a word boundary.
- Non-final words carry out_last=0 and out_pad=0.
- Accept and emit never occur in the same cycle, because accept requires cnt < OUT_WIDTH.
- A consumed word with no new load clears out_vld to 0.
- Latency: chunk accepted at edge k gives an earliest word with out_vld high after edge k+1.
- Throughput with continuous out_rdy: one word per 2 cycles for full-width chunks.
- Backpressure: while out_vld && !out_rdy, out_byte, out_last and out_pad hold stable. Accepts continue while cnt < OUT_WIDTH.
- en low:
  - No accept, no emit, no consumption; out_rdy is ignored.
  - Outputs hold.
  - in_rdy=0.
- in_len=0 without in_last is a legal no-op accept.
- After the final word is consumed the packer is idle (cnt=0, last_pend=0) and accepts a new stream.

Test Plan:
- Chunks len4 0xA, 0xB, 0xC, 0xD (last on the 4th), out_rdy=1 -> words 0xAB (last=0), then 0xCD (last=1, pad=0); then idle, in_rdy=1.
- Chunk len3 0b101, then len7 0b1100110 with last -> 0xB9 (last=0), then 0x80 (last=1, pad=6).
- Len8 0xFF then len8 0x00 last; out_rdy low for 5 cycles after the first out_vld:
  - 0xFF held stable; in_rdy=0 while cnt=8.
  - After release: 0xFF, then 0x00 (last=1, pad=0).
- Len0 chunk with in_last on an empty packer -> single word 0x00, last=1, pad=8.
- in_len=12 with in_bits=0xFF, last -> treated as len8: 0xFF, last=1, pad=0.
- en dropped for 4 cycles mid-stream -> no state or output change; stream completes identically afterwards.
- rst_n pulsed with 5 bits buffered -> all outputs 0; next stream (len4 0x3, len4 0xC last) yields 0x3C, last=1.
